// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: size encoding,
// FSM state encoding, default widths and the alignment check.
package dmem_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int IDX_W_DEF  = 11;
  localparam int ADDR_W_DEF = 40;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } size_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  // An access is aligned when the byte offset is a multiple of its size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE:  mis = 1'b0;
      SIZE_HALF:  mis = offset[0];
      SIZE_WORD:  mis = |offset[1:0];
      SIZE_DWORD: mis = |offset;
      default:    mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: extracts and extends load data, and merges store
// data into the word read back from memory.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_data
);

  logic [DATA_W-1:0] lane_mask_s;
  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] word_mask_s;
  logic              sign_s;
  int                lane_bits_s;

  // Build the right-aligned lane mask for the access size.
  always_comb begin
    lane_bits_s = int'(32'd8 << size);
    lane_mask_s = '0;
    for (int i = 0; i < DATA_W; i++) begin
      lane_mask_s[i] = (i < lane_bits_s);
    end
  end

  // Load path: shift the addressed bytes down, mask, then sign-extend.
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    case (size)
      SIZE_BYTE: sign_s = shifted_s[7];
      SIZE_HALF: sign_s = shifted_s[15];
      SIZE_WORD: sign_s = shifted_s[31];
      default:   sign_s = 1'b0;
    endcase
    if (!is_unsigned && sign_s) begin
      load_data = (shifted_s & lane_mask_s) | ~lane_mask_s;
    end else begin
      load_data = shifted_s & lane_mask_s;
    end
  end

  // Store path: replace only the addressed bytes of the read word.
  always_comb begin
    word_mask_s = lane_mask_s << {offset, 3'b000};
    store_data  = ((wdata << {offset, 3'b000}) & word_mask_s) | (rdata & ~word_mask_s);
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one load or read-modify-write store at a time
// against a single-port memory with one cycle of read latency.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_store_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_misaligned_o,
  output logic [IDX_W-1:0]  mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [2:0]        offset_r;
  logic              store_r;
  logic [1:0]        size_r;
  logic              unsigned_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              misaligned_r;

  logic              accept_s;
  logic              req_mis_s;
  logic [DATA_W-1:0] load_data_s;
  logic [DATA_W-1:0] store_data_s;
  logic              unused_addr_s;

  // Address bits above the word index alias onto the same memory.
  assign unused_addr_s = ^req_addr_i[ADDR_W-1:IDX_W+3];

  assign req_ready_o = (state_r == ST_IDLE) && !rst;
  assign accept_s    = req_valid_i && req_ready_o;
  assign req_mis_s   = is_misaligned(req_size_i, req_addr_i[2:0]);

  dmem_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .rdata       (mem_rdata_i),
    .wdata       (wdata_r),
    .offset      (offset_r),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .load_data   (load_data_s),
    .store_data  (store_data_s)
  );

  // Request capture and state sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      offset_r     <= 3'd0;
      store_r      <= 1'b0;
      size_r       <= 2'd0;
      unsigned_r   <= 1'b0;
      wdata_r      <= '0;
      rdata_r      <= '0;
      misaligned_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            idx_r        <= req_addr_i[IDX_W+2:3];
            offset_r     <= req_addr_i[2:0];
            store_r      <= req_store_i;
            size_r       <= req_size_i;
            unsigned_r   <= req_unsigned_i;
            wdata_r      <= req_wdata_i;
            rdata_r      <= '0;
            misaligned_r <= req_mis_s;
            state_r      <= req_mis_s ? ST_RESP : ST_READ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: state_r <= ST_DATA;
        ST_DATA: begin
          rdata_r <= store_r ? '0 : load_data_s;
          state_r <= ST_RESP;
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Memory and response drive; everything is forced quiet while rst is high.
  always_comb begin
    mem_addr_o        = '0;
    mem_we_o          = 1'b0;
    mem_wdata_o       = '0;
    resp_valid_o      = 1'b0;
    resp_rdata_o      = '0;
    resp_misaligned_o = 1'b0;
    if (!rst) begin
      if (state_r == ST_READ || state_r == ST_DATA) begin
        mem_addr_o = idx_r;
      end else begin
        mem_addr_o = '0;
      end
      if (state_r == ST_DATA && store_r) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = store_data_s;
      end else begin
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
      end
      if (state_r == ST_RESP) begin
        resp_valid_o      = 1'b1;
        resp_rdata_o      = rdata_r;
        resp_misaligned_o = misaligned_r;
      end else begin
        resp_valid_o      = 1'b0;
        resp_rdata_o      = '0;
        resp_misaligned_o = 1'b0;
      end
    end else begin
      mem_addr_o = '0;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural one-cycle-latency memory.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [39:0] req_addr;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic [63:0] mem [0:2047];
  logic        pre_we;
  logic [10:0] pre_addr;
  logic [63:0] pre_data;
  int          we_cnt;
  int          resp_cnt;
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_addr_i        (req_addr),
    .req_store_i       (req_store),
    .req_size_i        (req_size),
    .req_unsigned_i    (req_unsigned),
    .req_wdata_i       (req_wdata),
    .resp_valid_o      (resp_valid),
    .resp_rdata_o      (resp_rdata),
    .resp_misaligned_o (resp_misaligned),
    .mem_addr_o        (mem_addr),
    .mem_we_o          (mem_we),
    .mem_wdata_o       (mem_wdata),
    .mem_rdata_i       (mem_rdata)
  );

  // Memory model with a bench-side preload port, plus event counters.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (mem_we) we_cnt <= we_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [10:0] idx, input logic [63:0] data);
    pre_we = 1'b1; pre_addr = idx; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [39:0] addr, input logic st,
                        input logic [1:0] sz, input logic uns, input logic [63:0] wd,
                        input int exp_lat, input logic [63:0] exp_rd, input logic exp_mis,
                        input int exp_we);
    int we0, rs0, lat;
    we0 = we_cnt; rs0 = resp_cnt;
    req_valid = 1'b1; req_addr = addr; req_store = st; req_size = sz;
    req_unsigned = uns; req_wdata = wd;
    check({tag, "/ready_before"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "/busy_after_accept"}, 64'(req_ready), 64'd0);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/resp_seen"}, 64'(resp_valid), 64'd1);
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/rdata"}, resp_rdata, exp_rd);
    check({tag, "/misaligned"}, 64'(resp_misaligned), 64'(exp_mis));
    @(posedge clk); #1;
    check({tag, "/resp_single"}, 64'(resp_valid), 64'd0);
    check({tag, "/rdata_idle"}, resp_rdata, 64'd0);
    check({tag, "/ready_again"}, 64'(req_ready), 64'd1);
    check({tag, "/writes"}, 64'(we_cnt - we0), 64'(exp_we));
    check({tag, "/resp_count"}, 64'(resp_cnt - rs0), 64'd1);
  endtask

  initial begin
    int we0, rs0;
    rst = 1'b1; pre_we = 1'b0; pre_addr = 11'd0; pre_data = 64'd0;
    we_cnt = 0; resp_cnt = 0; checks = 0; errors = 0;
    req_valid = 1'b1; req_addr = 40'h28; req_store = 1'b1; req_size = 2'd3;
    req_unsigned = 1'b0; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;

    // Preload memory while the controller is held in reset with a request pending.
    poke(11'd5, 64'h1122_3344_5566_7788);
    poke(11'd0, 64'h0000_0000_0000_80FF);
    poke(11'd2, 64'hAAAA_AAAA_AAAA_AAAA);
    poke(11'd1, 64'h0000_0000_0000_0000);
    poke(11'd3, 64'h0123_4567_89AB_CDEF);
    check("rst/ready", 64'(req_ready), 64'd0);
    check("rst/resp_valid", 64'(resp_valid), 64'd0);
    check("rst/resp_rdata", resp_rdata, 64'd0);
    check("rst/resp_mis", 64'(resp_misaligned), 64'd0);
    check("rst/mem_we", 64'(mem_we), 64'd0);
    check("rst/mem_addr", 64'(mem_addr), 64'd0);
    check("rst/mem_wdata", mem_wdata, 64'd0);
    check("rst/no_writes", 64'(we_cnt), 64'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst/ready", 64'(req_ready), 64'd1);

    // Dword load with an address probe during READ.
    req_valid = 1'b1; req_addr = 40'h28; req_store = 1'b0; req_size = 2'd3;
    req_unsigned = 1'b0; req_wdata = 64'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ld_d/mem_addr_read", 64'(mem_addr), 64'd5);
    repeat (3) @(posedge clk);
    #1;
    check("ld_d/mem_addr_idle", 64'(mem_addr), 64'd0);
    do_req("ld_d", 40'h28, 1'b0, 2'd3, 1'b0, 64'd0, 2, 64'h1122_3344_5566_7788, 1'b0, 0);

    do_req("ld_b_s", 40'h1, 1'b0, 2'd0, 1'b0, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 0);
    do_req("ld_b_u", 40'h1, 1'b0, 2'd0, 1'b1, 64'd0, 2, 64'h0000_0000_0000_0080, 1'b0, 0);

    do_req("st_h", 40'h14, 1'b1, 2'd1, 1'b0, 64'h1234, 2, 64'd0, 1'b0, 1);
    check("st_h/mem2", mem[2], 64'hAAAA_1234_AAAA_AAAA);

    do_req("mis_w", 40'h6, 1'b0, 2'd2, 1'b0, 64'd0, 0, 64'd0, 1'b1, 0);
    do_req("alias", 40'h4028, 1'b0, 2'd3, 1'b0, 64'd0, 2, 64'h1122_3344_5566_7788, 1'b0, 0);
    do_req("ld_h_s", 40'h1A, 1'b0, 2'd1, 1'b0, 64'd0, 2, 64'hFFFF_FFFF_FFFF_89AB, 1'b0, 0);
    do_req("ld_w_s", 40'h1C, 1'b0, 2'd2, 1'b0, 64'd0, 2, 64'h0000_0000_0123_4567, 1'b0, 0);
    do_req("st_b", 40'h1F, 1'b1, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF5A, 2, 64'd0, 1'b0, 1);
    check("st_b/mem3", mem[3], 64'h5A23_4567_89AB_CDEF);
    do_req("ld_h_u", 40'h1E, 1'b0, 2'd1, 1'b1, 64'd0, 2, 64'h0000_0000_0000_5A23, 1'b0, 0);
    do_req("mis_st", 40'hB, 1'b1, 2'd1, 1'b0, 64'hFFFF, 0, 64'd0, 1'b1, 0);
    check("mis_st/mem1", mem[1], 64'd0);
    do_req("mis_d", 40'h4, 1'b0, 2'd3, 1'b0, 64'd0, 0, 64'd0, 1'b1, 0);

    // Reset raised while a store sits in DATA.
    we0 = we_cnt; rs0 = resp_cnt;
    req_valid = 1'b1; req_addr = 40'h8; req_store = 1'b1; req_size = 2'd3;
    req_unsigned = 1'b0; req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_st/mem_addr_read", 64'(mem_addr), 64'd1);
    @(posedge clk); #1;
    check("rst_st/we_in_data", 64'(mem_we), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_st/we_gated", 64'(mem_we), 64'd0);
    check("rst_st/wdata_gated", mem_wdata, 64'd0);
    check("rst_st/addr_gated", 64'(mem_addr), 64'd0);
    @(posedge clk); #1;
    check("rst_st/ready_in_rst", 64'(req_ready), 64'd0);
    check("rst_st/resp_in_rst", 64'(resp_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_st/ready_after", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    check("rst_st/no_write", 64'(we_cnt - we0), 64'd0);
    check("rst_st/no_resp", 64'(resp_cnt - rs0), 64'd0);
    check("rst_st/mem1", mem[1], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
